// File: rtl/vsevenseg_pkg.sv
// Shared constants for the scanned seven-segment driver.
package vsevenseg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  // Bit positions within a segment vector {g,f,e,d,c,b,a}
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  typedef logic [SEG_W-1:0] seg_t;

  // All segments dark, active-high sense
  localparam seg_t SEG_OFF = 7'h00;

  // Active-high hex glyphs 0..F (lower-case b and d)
  localparam seg_t SEG_PATTERN [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/vsevenseg_scan_dec.sv
// Shared combinational hex-to-seven-segment decoder, active-high outputs.
module hex7seg_dec
  import vsevenseg_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output seg_t             seg_c
);

  // Table lookup of the glyph for one nibble
  always_comb begin
    seg_c = SEG_PATTERN[nibble];
  end

endmodule

// File: rtl/vsevenseg_scan.sv
// Time-multiplexed seven-segment driver with double-buffered data and blanking.
module vsevenseg_scan
  import vsevenseg_pkg::*;
#(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                     clk,
  input  logic                     rst_L,
  input  logic [NIB_W*NDIGITS-1:0] value,
  input  logic [NDIGITS-1:0]       dp_in,
  input  logic                     load,
  input  logic [NDIGITS-1:0]       en_mask,
  input  logic                     blank_lz,
  output logic [SEG_W-1:0]         seg_L,
  output logic                     dp_L,
  output logic [NDIGITS-1:0]       anode_L,
  output logic                     frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned VW = NIB_W * NDIGITS;

  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NDIGITS - 1);

  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [VW-1:0]      shadow_val_q, shadow_val_d;
  logic [NDIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VW-1:0]      active_val_q, active_val_d;
  logic [NDIGITS-1:0] active_dp_q, active_dp_d;
  logic               pending_q, pending_d;
  seg_t               seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [NDIGITS-1:0] anode_q, anode_d;
  logic               frame_done_q, frame_done_d;

  logic               tick_c;
  logic               wrap_c;
  logic [NIB_W-1:0]   sel_nib_c;
  logic               sel_dp_c;
  logic               sel_lz_c;
  logic               sel_en_c;
  logic               blank_c;
  seg_t               dec_seg_c;

  // Prescaler and digit scan counter; the last-digit tick is the frame wrap
  always_comb begin
    tick_c = (pcnt_q == PCNT_MAX);
    wrap_c = tick_c && (idx_q == IDX_MAX);
    pcnt_d = tick_c ? '0 : pcnt_q + PW'(1);
    idx_d  = idx_q;
    if (tick_c) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Shadow capture on load; shadow-to-active transfer only at the frame wrap
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end
    if (wrap_c) begin
      if (load) begin
        active_val_d = value;
        active_dp_d  = dp_in;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end
    end
  end

  // Pick the digit about to be shown and work out whether it is blanked
  always_comb begin : sel_comb
    logic zero_run;
    zero_run  = 1'b1;
    sel_nib_c = '0;
    sel_dp_c  = 1'b0;
    sel_lz_c  = 1'b0;
    sel_en_c  = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (active_val_d[NIB_W*i +: NIB_W] == '0);
      if (IW'(i) == idx_d) begin
        sel_nib_c = active_val_d[NIB_W*i +: NIB_W];
        sel_dp_c  = active_dp_d[i];
        sel_lz_c  = zero_run && (i > 0);
        sel_en_c  = en_mask[i];
      end
    end
    blank_c = !sel_en_c || (blank_lz && sel_lz_c);
  end

  hex7seg_dec u_dec (
    .nibble (sel_nib_c),
    .seg_c  (dec_seg_c)
  );

  // Next output pins: anode and segments are computed together so they switch on one edge
  always_comb begin
    seg_d        = blank_c ? ~SEG_OFF : ~dec_seg_c;
    dp_d         = blank_c ? 1'b1 : ~sel_dp_c;
    anode_d      = '1;
    frame_done_d = wrap_c;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!blank_c && (IW'(i) == idx_d)) begin
        anode_d[i] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      seg_q        <= ~SEG_OFF;
      dp_q         <= 1'b1;
      anode_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      anode_q      <= anode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_L      = seg_q;
  assign dp_L       = dp_q;
  assign anode_L    = anode_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_vsevenseg_scan.sv
// Scoreboard bench for vsevenseg_scan: expected frames are queued, a monitor checks each frame.
`timescale 1ns/1ps
module tb_vsevenseg_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 3;
  localparam int FC = ND * RD;

  typedef struct packed {
    logic [3:0][6:0] seg;   // expected active-low segments per digit
    logic [3:0]      dark;  // digit fully blanked
    logic [3:0]      dp;    // decimal point lit
  } frame_t;

  logic        clk;
  logic        rst_L;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  en_mask;
  logic        blank_lz;
  logic [6:0]  seg_L;
  logic        dp_L;
  logic [3:0]  anode_L;
  logic        frame_done;
  logic [6:0]  seg1;
  logic        dp1;
  logic [3:0]  anode1;
  logic        frame_done1;

  int tests;
  int fails;
  bit mon_en;
  frame_t exp_q[$];

  vsevenseg_scan #(.NDIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst_L(rst_L), .value(value), .dp_in(dp_in), .load(load),
    .en_mask(en_mask), .blank_lz(blank_lz), .seg_L(seg_L), .dp_L(dp_L),
    .anode_L(anode_L), .frame_done(frame_done)
  );

  vsevenseg_scan #(.NDIGITS(ND), .REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_L(rst_L), .value(value), .dp_in(dp_in), .load(load),
    .en_mask(en_mask), .blank_lz(blank_lz), .seg_L(seg1), .dp_L(dp1),
    .anode_L(anode1), .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input logic [3:0] dark, input logic [3:0] dp);
    frame_t f;
    f.seg  = {s3, s2, s1, s0};
    f.dark = dark;
    f.dp   = dp;
    return f;
  endfunction

  // Monitor: on each frame_done start a frame, pop its expectation, check digit by digit
  initial begin : monitor
    int cyc;
    int d;
    bit have;
    bit bad;
    frame_t cur;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic [3:0] ba, xa;
    logic [6:0] bs, xs;
    logic       bd, xd;
    cyc = -1; have = 0; bad = 0; cur = '0;
    ba = '0; bs = '0; bd = 1'b0; xa = '0; xs = '0; xd = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        cyc = -1; have = 0; bad = 0;
        continue;
      end
      if (frame_done === 1'b1) begin
        if (cyc != -1) check("frame_period", 32'(cyc), 32'(FC - 1));
        cyc = 0; bad = 0;
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          have = 1;
        end else begin
          have = 0;
        end
      end else if (cyc != -1) begin
        cyc++;
        if (cyc >= FC) begin
          check("frame_done_seen", 32'(frame_done), 32'(1));
          cyc = -1; have = 0; bad = 0;
        end
      end
      if (have && cyc >= 0) begin
        d = cyc / RD;
        if (cur.dark[d]) begin
          ea = 4'hF; es = 7'h7F; ed = 1'b1;
        end else begin
          ea = ~(4'(1) << d); es = cur.seg[d]; ed = ~cur.dp[d];
        end
        if (!bad && (anode_L !== ea || seg_L !== es || dp_L !== ed)) begin
          bad = 1;
          ba = anode_L; bs = seg_L; bd = dp_L;
          xa = ea; xs = es; xd = ed;
        end
        if ((cyc % RD) == RD - 1) begin
          tests++;
          if (bad) begin
            fails++;
            $display("FAIL digit%0d: anode %b seg %h dp %b, expected anode %b seg %h dp %b",
                     d, ba, bs, bd, xa, xs, xd);
          end
          bad = 0;
        end
      end
    end
  end

  // Advance to the negedge of the next frame's first cycle
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (frame_done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_frame: frame_done absent for 60 cycles");
    end
  endtask

  // Drive inputs on the wrap cycle of the next frame and queue the frame that should follow
  task automatic apply_at_wrap(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en,
                               input logic blz, input logic ld, input frame_t e);
    wait_frame();
    repeat (FC - 1) @(negedge clk);
    value = v; dp_in = dp; en_mask = en; blank_lz = blz; load = ld;
    exp_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0] prev;
    logic [3:0] nxt;
    frame_t zeros;
    tests = 0; fails = 0; mon_en = 0;
    rst_L = 1'b0; value = '0; dp_in = '0; load = 1'b0; en_mask = 4'hF; blank_lz = 1'b0;
    zeros = mk(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000, 4'b0000);

    // 1. reset state, then scan of "0000"
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg_L), 32'h7F);
    check("reset_dp", 32'(dp_L), 32'h1);
    check("reset_anode", 32'(anode_L), 32'hF);
    check("reset_frame_done", 32'(frame_done), 32'h0);
    check("reset_anode_div1", 32'(anode1), 32'hF);
    rst_L = 1'b1;
    @(negedge clk);
    check("first_anode", 32'(anode_L), 32'hE);
    check("first_seg", 32'(seg_L), 32'h40);
    check("first_dp", 32'(dp_L), 32'h1);
    prev = anode1;
    check("div1_one_low", 32'($countones(prev)), 32'd3);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nxt = {prev[2:0], prev[3]};
      check("div1_anode_step", 32'(anode1), 32'(nxt));
      check("div1_frame_done", 32'(frame_done1), 32'(nxt == 4'b1110));
      check("div1_seg", 32'(seg1), 32'h40);
      prev = nxt;
    end
    mon_en = 1;
    exp_q.push_back(zeros);
    wait_frame();
    @(negedge clk);
    exp_q.push_back(zeros);

    // 2. decode sweep
    apply_at_wrap(16'hFEDC, 4'h0, 4'hF, 1'b0, 1'b1, mk(7'h0E, 7'h06, 7'h21, 7'h46, 4'h0, 4'h0));
    apply_at_wrap(16'hBA98, 4'h0, 4'hF, 1'b0, 1'b1, mk(7'h03, 7'h08, 7'h10, 7'h00, 4'h0, 4'h0));
    apply_at_wrap(16'h7654, 4'h0, 4'hF, 1'b0, 1'b1, mk(7'h78, 7'h02, 7'h12, 7'h19, 4'h0, 4'h0));
    apply_at_wrap(16'h3210, 4'h0, 4'hF, 1'b0, 1'b1, mk(7'h30, 7'h24, 7'h79, 7'h40, 4'h0, 4'h0));

    // 3. tear-free update: two mid-frame loads, only the last shows and only after the wrap
    wait_frame();
    @(negedge clk);
    exp_q.push_back(mk(7'h30, 7'h24, 7'h79, 7'h40, 4'h0, 4'h0));
    wait_frame();
    @(negedge clk);
    exp_q.push_back(mk(7'h12, 7'h02, 7'h78, 7'h00, 4'h0, 4'h0));
    repeat (2) @(negedge clk);
    value = 16'h1234; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    value = 16'h5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;

    // 4. load on the wrap tick overrides a pending load
    wait_frame();
    repeat (3) @(negedge clk);
    value = 16'h1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("pending_set", 32'(dut.pending_q), 32'h1);
    repeat (7) @(negedge clk);
    value = 16'hABCD; load = 1'b1;
    exp_q.push_back(mk(7'h08, 7'h03, 7'h46, 7'h21, 4'h0, 4'h0));
    @(negedge clk);
    load = 1'b0;
    check("wrap_load_frame_done", 32'(frame_done), 32'h1);
    check("wrap_load_digit0", 32'(seg_L), 32'h21);
    check("pending_clear", 32'(dut.pending_q), 32'h0);

    // 5. leading-zero blanking, enable mask and decimal point
    apply_at_wrap(16'h0050, 4'h0, 4'hF, 1'b1, 1'b1, mk(7'h7F, 7'h7F, 7'h12, 7'h40, 4'b1100, 4'h0));
    apply_at_wrap(16'h0000, 4'h0, 4'hF, 1'b1, 1'b1, mk(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'b1110, 4'h0));
    apply_at_wrap(16'h0000, 4'h0, 4'b1110, 1'b1, 1'b0, mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b1111, 4'h0));
    apply_at_wrap(16'h0050, 4'b0010, 4'hF, 1'b1, 1'b1, mk(7'h7F, 7'h7F, 7'h12, 7'h40, 4'b1100, 4'b0010));
    apply_at_wrap(16'h0000, 4'h0, 4'hF, 1'b0, 1'b0, mk(7'h40, 7'h40, 7'h12, 7'h40, 4'b0000, 4'b0010));
    apply_at_wrap(16'h0000, 4'h0, 4'b1010, 1'b0, 1'b0, mk(7'h40, 7'h7F, 7'h12, 7'h7F, 4'b0101, 4'b0010));

    // 6. reset mid-frame with a load pending
    wait_frame();
    en_mask = 4'hF; blank_lz = 1'b0;
    @(negedge clk);
    value = 16'h9999; dp_in = 4'hF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 0;
    rst_L = 1'b0;
    @(negedge clk);
    check("midreset_seg", 32'(seg_L), 32'h7F);
    check("midreset_anode", 32'(anode_L), 32'hF);
    check("midreset_dp", 32'(dp_L), 32'h1);
    check("midreset_frame_done", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    check("restart_anode", 32'(anode_L), 32'hE);
    check("restart_seg", 32'(seg_L), 32'h40);
    check("restart_pending", 32'(dut.pending_q), 32'h0);
    mon_en = 1;
    exp_q.push_back(zeros);
    repeat (3 * FC) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
